traffic_intersection_ctrl: RTL
==============================

// Module: traffic_intersection_ctrl
// PURPOSE
//  Two-road (NS/EW) intersection controller. Timed phases, configurable through parameters.
//  Adds all-red clearance, a latched pedestrian request that shortens green, a walk phase
//  and a flashing maintenance mode. It advances on an external timebase strobe (tick) from
//  the system prescaler. Light encoding is RED=2'b00, YELLOW=2'b01, GREEN=2'b10, OFF=2'b11.
// PARAMETERS
//  CNT_W        8   phase timer width; every T_* value must satisfy 1 <= T_* <= 2**CNT_W
//  T_GREEN     20   green duration, ticks
//  T_MIN_GREEN  6   minimum green before a pedestrian request may end it (1..T_GREEN)
//  T_YELLOW     4   yellow duration, ticks
//  T_ALLRED     2   all-red clearance duration, ticks
//  T_WALK      10   walk phase duration, ticks
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high reset
//  tick      in   1  timebase strobe, one clk wide; all timing counts ticks only
//  ped_req   in   1  pedestrian button, pulse or level, sampled every clk
//  flash_en  in   1  maintenance flash request (level)
//  ns_light  out  2  NS signal head
//  ew_light  out  2  EW signal head
//  walk      out  1  pedestrian walk lamp
//  ped_pend  out  1  pedestrian request latched and not yet served
//  phase     out  3  current state code (see below), for debug and status
// BEHAVIOUR
//  States and phase codes: NS_G=0, NS_Y=1, AR_A=2, EW_G=3, EW_Y=4, AR_B=5, WALK=6, FLASH=7.
//  Reset (asynchronous): state=AR_B, timer=0, next_dir=NS, ped_pend=0, blink=0.
//   Outputs while in reset: ns=ew=RED, walk=0, phase=5.
//  Timer: set to 0 on every state entry. It increments only on cycles with tick=1.
//   A state of duration T exits on the tick when timer==T-1, so it lasts exactly T ticks.
//   The new state is visible the clk after that tick. With tick=0 the FSM is frozen.
//  Sequence: NS_G -> NS_Y -> AR_A -> EW_G -> EW_Y -> AR_B -> NS_G ...
//  Green exit (tick=1): timer==T_GREEN-1, or ped_pend=1 with timer>=T_MIN_GREEN-1.
//  All-red exit (AR_A or AR_B, tick=1, timer==T_ALLRED-1). Priority order:
//   flash_en=1 -> FLASH; else ped_pend=1 -> WALK; else next green (AR_A->EW_G, AR_B->NS_G).
//   next_dir records which green follows, so WALK resumes the correct direction.
//  WALK: ns=ew=RED, walk=1. Lasts T_WALK ticks, then goes to the green selected by next_dir.
//  ped_pend: set on any clk with ped_req=1, except while in WALK or on the WALK-entry clk.
//   Requests in those cycles are dropped. ped_pend clears on WALK entry.
//   A request during AR_x on the exit tick is taken into account on that same tick.
//  FLASH: the blink bit toggles on every tick. ns = blink ? YELLOW : OFF; ew = blink ? RED : OFF.
//   blink is 0 on entry. walk=0. ped_pend keeps latching.
//   Exit on a tick with flash_en=0 -> AR_B, with next_dir=NS.
//  Outputs are registered from the state (Moore) and glitch-free: at most one head is
//   non-RED outside FLASH, and conflicting greens never occur.
//  Reset mid-phase returns to AR_B at once. A pending request is lost.
// TESTING (T_GREEN=5, T_MIN_GREEN=2, T_YELLOW=2, T_ALLRED=1, T_WALK=3, tick=1 every clk)
//  1 reset held 3 clk then released -> both RED, phase=5 for 1 clk; then ns=GREEN, phase=0.
//  2 free run, no requests -> per-state clk counts NS_G 5, NS_Y 2, AR_A 1, EW_G 5, EW_Y 2,
//    AR_B 1; the period repeats every 16 clk; ns and ew are never both GREEN.
//  3 ped_req pulse at NS_G timer=0 -> ped_pend=1; NS_G ends after 2 ticks; NS_Y 2, AR_A 1;
//    then WALK: walk=1 for 3 clk, ped_pend=0; then EW_G.
//  4 ped_req in WALK -> dropped (ped_pend stays 0); tick held 0 for 10 clk mid-EW_G ->
//    phase and timer frozen; on resume the remaining duration is unchanged.
//  5 flash_en=1 during NS_G -> normal sequence to AR_A, then FLASH; ns alternates
//    OFF/YELLOW and ew OFF/RED on each tick; flash_en=0 -> AR_B, then NS_G.
//  6 reset asserted asynchronously mid-EW_Y with ped_pend=1 -> same cycle: both RED,
//    phase=5, ped_pend=0, walk=0.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Two-road (NS/EW) intersection controller.
// Timed green/yellow/all-red phases advanced by an external tick strobe, with a
// latched pedestrian request that can shorten green and insert a walk phase,
// plus a flashing maintenance mode entered from an all-red clearance.
// Light encoding: RED=00, YELLOW=01, GREEN=10, OFF=11.
module traffic_intersection_ctrl #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN     = 20,
    parameter int T_MIN_GREEN = 6,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2,
    parameter int T_WALK      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_pend,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_A  = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_B  = 3'd5,
        WALK  = 3'd6,
        FLASH = 3'd7
    } state_t;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    // Last timer value of each phase: a phase of T ticks exits when timer == T-1.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(T_WALK - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   timer_reg, timer_next;
    logic               next_dir_reg, next_dir_next;   // 0: NS green follows, 1: EW green follows
    logic               ped_pend_reg, ped_pend_next;
    logic               blink_reg, blink_next;
    logic [1:0]         ns_light_reg, ew_light_reg;
    logic               walk_reg;
    logic               done;
    logic               ped_any;
    logic [4:0]         lamps_next;

    // Signal-head decode for a given state; {ns, ew, walk}.
    function automatic logic [4:0] decode(input state_t s, input logic b);
        logic [1:0] ns;
        logic [1:0] ew;
        logic       wk;
        ns = RED;
        ew = RED;
        wk = 1'b0;
        case (s)
            NS_G:    ns = GREEN;
            NS_Y:    ns = YELLOW;
            EW_G:    ew = GREEN;
            EW_Y:    ew = YELLOW;
            WALK:    wk = 1'b1;
            FLASH: begin
                ns = b ? YELLOW : OFF;
                ew = b ? RED : OFF;
            end
            default: ;
        endcase
        return {ns, ew, wk};
    endfunction

    // Next-state, timer, direction memory, pedestrian latch and blink logic.
    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        next_dir_next = next_dir_reg;
        ped_pend_next = ped_pend_reg;
        blink_next    = blink_reg;
        done          = 1'b0;
        // A request arriving on the all-red exit tick still diverts into WALK.
        ped_any       = ped_pend_reg | ped_req;

        case (state_reg)
            NS_G, EW_G: done = (timer_reg == GREEN_LAST) ||
                               (ped_pend_reg && (timer_reg >= MIN_LAST));
            NS_Y, EW_Y: done = (timer_reg == YELLOW_LAST);
            AR_A, AR_B: done = (timer_reg == ALLRED_LAST);
            WALK:       done = (timer_reg == WALK_LAST);
            FLASH:      done = !flash_en;
            default:    done = 1'b0;
        endcase

        if (tick) begin
            if (done) begin
                timer_next = '0;
                case (state_reg)
                    NS_G: state_next = NS_Y;
                    NS_Y: state_next = AR_A;
                    EW_G: state_next = EW_Y;
                    EW_Y: state_next = AR_B;
                    AR_A, AR_B: begin
                        next_dir_next = (state_reg == AR_A);
                        if (flash_en)
                            state_next = FLASH;
                        else if (ped_any)
                            state_next = WALK;
                        else
                            state_next = (state_reg == AR_A) ? EW_G : NS_G;
                    end
                    WALK:  state_next = next_dir_reg ? EW_G : NS_G;
                    FLASH: begin
                        state_next    = AR_B;
                        next_dir_next = 1'b0;
                    end
                    default: state_next = AR_B;
                endcase
            end else if (state_reg != FLASH) begin
                timer_next = timer_reg + CNT_W'(1);
            end
            if (state_reg == FLASH)
                blink_next = ~blink_reg;
        end

        if ((state_next == FLASH) && (state_reg != FLASH))
            blink_next = 1'b0;

        // Requests are dropped while walking and on the clk that enters WALK.
        if ((state_next == WALK) && (state_reg != WALK))
            ped_pend_next = 1'b0;
        else if ((state_reg != WALK) && ped_req)
            ped_pend_next = 1'b1;
    end

    assign lamps_next = decode(state_next, blink_next);

    // State and output registers; reset forces the all-red clearance at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= AR_B;
            timer_reg    <= '0;
            next_dir_reg <= 1'b0;
            ped_pend_reg <= 1'b0;
            blink_reg    <= 1'b0;
            ns_light_reg <= RED;
            ew_light_reg <= RED;
            walk_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            next_dir_reg <= next_dir_next;
            ped_pend_reg <= ped_pend_next;
            blink_reg    <= blink_next;
            ns_light_reg <= lamps_next[4:3];
            ew_light_reg <= lamps_next[2:1];
            walk_reg     <= lamps_next[0];
        end
    end

    assign ns_light = ns_light_reg;
    assign ew_light = ew_light_reg;
    assign walk     = walk_reg;
    assign ped_pend = ped_pend_reg;
    assign phase    = state_reg;

endmodule
